// File: rtl/program_counter_preset.sv
// Program counter with a two-channel preset mux feeding its load path.
// Latency: preset is combinational; load/inc reach q one cycle after the edge.
// No backpressure: every load or inc is accepted in the cycle it is asserted.
module program_counter_preset #(
    parameter int                WIDTH       = 16,
    parameter int                STEP        = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ch0,
    input  logic [WIDTH-1:0] ch1,
    input  logic             sel,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] preset,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] w_preset;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] r_q;

    always_comb begin
        w_preset = sel ? ch1 : ch0;
    end

    // Load beats inc; the sum is truncated to WIDTH so the carry is dropped.
    always_comb begin
        w_q_next = r_q;
        if (load) begin
            w_q_next = w_preset;
        end else if (inc) begin
            w_q_next = r_q + STEP_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign preset = w_preset;
    assign q      = r_q;

endmodule

// File: tb/tb_program_counter_preset.sv
// Directed bench for program_counter_preset: vector table plus hand-written
// sequences for combinational preset switching and a mid-count reset.
module tb_program_counter_preset;

    logic        clk;
    logic        rst;
    logic [15:0] ch0;
    logic [15:0] ch1;
    logic        sel;
    logic        load;
    logic        inc;
    logic [15:0] preset;
    logic [15:0] q;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        rst;
        logic        load;
        logic        inc;
        logic        sel;
        logic [15:0] ch0;
        logic [15:0] ch1;
        logic [15:0] exp_preset;
        logic [15:0] exp_q;
    } vec_t;

    vec_t vq[$];

    program_counter_preset #(
        .WIDTH(16),
        .STEP(1),
        .RESET_VALUE(16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ch0(ch0),
        .ch1(ch1),
        .sel(sel),
        .load(load),
        .inc(inc),
        .preset(preset),
        .q(q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic l, input logic i, input logic s,
                         input logic [15:0] c0, input logic [15:0] c1);
        rst  = r;
        load = l;
        inc  = i;
        sel  = s;
        ch0  = c0;
        ch1  = c1;
    endtask

    task automatic add(input logic r, input logic l, input logic i, input logic s,
                       input logic [15:0] c0, input logic [15:0] c1,
                       input logic [15:0] ep, input logic [15:0] eq);
        vec_t v;
        v = '{r, l, i, s, c0, c1, ep, eq};
        vq.push_back(v);
    endtask

    // Drive on the falling edge, check preset before the rising edge and q just after it.
    task automatic step(input string name, input logic [15:0] eq);
        #1;
        check({name, ".preset"}, preset, (sel ? ch1 : ch0));
        @(posedge clk);
        #1;
        check({name, ".q"}, q, eq);
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'd34, 16'd54);

        // rst, load, inc, sel, ch0, ch1, expected preset, expected q
        add(1, 1, 0, 0, 16'd34,  16'd54,  16'd34,  16'h0000); // reset beats load
        add(1, 1, 0, 0, 16'd34,  16'd54,  16'd34,  16'h0000);
        add(0, 1, 0, 0, 16'd34,  16'd54,  16'd34,  16'd34);   // load ch0
        add(0, 1, 0, 1, 16'd34,  16'd54,  16'd54,  16'd54);   // load ch1
        add(0, 0, 0, 0, 16'd100, 16'd200, 16'd100, 16'd54);   // hold while inputs change
        add(0, 0, 0, 1, 16'd100, 16'd200, 16'd200, 16'd54);
        add(0, 0, 0, 0, 16'd7,   16'd200, 16'd7,   16'd54);
        add(0, 0, 0, 1, 16'd7,   16'd9,   16'd9,   16'd54);
        add(0, 1, 0, 1, 16'd34,  16'd54,  16'd54,  16'd54);   // reload 54
        add(0, 0, 1, 1, 16'd34,  16'd54,  16'd54,  16'd55);
        add(0, 0, 1, 1, 16'd34,  16'd54,  16'd54,  16'd56);
        add(0, 0, 1, 1, 16'd34,  16'd54,  16'd54,  16'd57);
        add(0, 1, 1, 0, 16'd34,  16'd54,  16'd34,  16'd34);   // load beats inc, no +STEP
        add(0, 1, 0, 1, 16'd34,  16'hFFFE, 16'hFFFE, 16'hFFFE);
        add(0, 0, 1, 1, 16'd34,  16'hFFFE, 16'hFFFE, 16'hFFFF);
        add(0, 0, 1, 1, 16'd34,  16'hFFFE, 16'hFFFE, 16'h0000); // wrap, carry dropped
        add(0, 0, 1, 1, 16'd34,  16'hFFFE, 16'hFFFE, 16'h0001);

        @(negedge clk);
        foreach (vq[k]) begin
            drive(vq[k].rst, vq[k].load, vq[k].inc, vq[k].sel, vq[k].ch0, vq[k].ch1);
            #1;
            check($sformatf("vec%0d.preset", k), preset, vq[k].exp_preset);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.q", k), q, vq[k].exp_q);
            @(negedge clk);
        end

        // preset follows sel mid-cycle with no clock edge involved
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd34, 16'd54);
        #1;
        check("comb.sel0", preset, 16'd34);
        sel = 1'b1;
        #1;
        check("comb.sel1", preset, 16'd54);
        ch1 = 16'hA5A5;
        #1;
        check("comb.ch1", preset, 16'hA5A5);
        check("comb.q_hold", q, 16'h0001);
        @(negedge clk);

        // reset in the middle of an inc stream, then counting resumes from zero
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000);
        step("mid.load", 16'h0100);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000);
        step("mid.inc1", 16'h0101);
        step("mid.inc2", 16'h0102);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000);
        step("mid.rst", 16'h0000);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000);
        step("mid.resume1", 16'h0001);
        step("mid.resume2", 16'h0002);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000);
        step("mid.hold", 16'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
